// File: rtl/arb_iwrr_weight_tracker_pkg.sv
// Shared IWRR arbiter definitions: zero-weight handling and
// saturating counter limits, reused by every IWRR stage.
package arb_iwrr_weight_tracker_pkg;

    // A programmed weight of zero still earns one grant per round.
    localparam int unsigned ZERO_WEIGHT_EW = 1;

    function automatic int unsigned cnt_sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/arb_weight_counter.sv
// Per-requester grant counter for the IWRR weight tracker.
// Saturates at all-ones; load1 opens a new round with this grant.
module arb_weight_counter
    import arb_iwrr_weight_tracker_pkg::*;
#(
    parameter int P_WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load1,
    input  logic                  inc,
    input  logic [P_WEIGHT_W-1:0] ew,
    output logic [P_WEIGHT_W-1:0] cnt,
    output logic                  completed
);

    localparam logic [P_WEIGHT_W-1:0] CNT_MAX =
        P_WEIGHT_W'(cnt_sat_max(P_WEIGHT_W));
    localparam logic [P_WEIGHT_W-1:0] CNT_ONE = P_WEIGHT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CNT_ONE;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign completed = (cnt >= ew);

endmodule

// File: rtl/arb_iwrr_weight_tracker.sv
// IWRR weight accounting: counts accepted grants per requester,
// flags exhausted weights and closes rounds.
module arb_iwrr_weight_tracker
    import arb_iwrr_weight_tracker_pkg::*;
#(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [P_REQUESTER_NUM-1:0]            request,
    input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight,
    input  logic [P_REQUESTER_NUM-1:0]            grant,
    input  logic                                  grant_accept,
    output logic [P_REQUESTER_NUM-1:0]            request_weight_completed,
    output logic                                  round_done
);

    localparam int NW = P_REQUESTER_NUM * P_WEIGHT_W;

    logic [P_REQUESTER_NUM-1:0] pending;
    logic [NW-1:0]              cnt_flat;
    logic                       accept;
    logic                       round_close;
    logic                       idle_clr;
    logic                       clr_all;

    assign accept      = grant_accept & (|grant);
    assign pending     = request & ~request_weight_completed;
    assign round_close = accept & ~(|pending);
    // Skip the idle clear when every counter is already zero.
    assign idle_clr    = ~(|request) & ~accept & (|cnt_flat);
    assign clr_all     = round_close | idle_clr;

    for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_req
        logic [P_WEIGHT_W-1:0] w_i;
        logic [P_WEIGHT_W-1:0] ew_i;

        assign w_i  = weight[i*P_WEIGHT_W +: P_WEIGHT_W];
        assign ew_i = (w_i == '0) ? P_WEIGHT_W'(ZERO_WEIGHT_EW) : w_i;

        arb_weight_counter #(
            .P_WEIGHT_W (P_WEIGHT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr_all),
            .load1     (round_close & grant[i]),
            .inc       (accept & ~round_close & grant[i]),
            .ew        (ew_i),
            .cnt       (cnt_flat[i*P_WEIGHT_W +: P_WEIGHT_W]),
            .completed (request_weight_completed[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_done <= 1'b0;
        end else begin
            round_done <= round_close;
        end
    end

endmodule

// File: tb/tb_arb_iwrr_weight_tracker.sv
// Scoreboard bench for arb_iwrr_weight_tracker: directed vectors
// push expected outputs, a monitor pops and compares after each edge.
module tb_arb_iwrr_weight_tracker;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [11:0] wt;
    logic [2:0]  gnt;
    logic        acc;
    logic [2:0]  cmp;
    logic        rd;

    logic [1:0]  req2;
    logic [3:0]  wt2;
    logic [1:0]  gnt2;
    logic        acc2;
    logic [1:0]  cmp2;
    logic        rd2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         d2;
        logic [2:0] ec;
        logic       erd;
        string      nm;
    } exp_t;

    exp_t q[$];

    arb_iwrr_weight_tracker dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .request                  (req),
        .weight                   (wt),
        .grant                    (gnt),
        .grant_accept             (acc),
        .request_weight_completed (cmp),
        .round_done               (rd)
    );

    arb_iwrr_weight_tracker #(
        .P_REQUESTER_NUM (2),
        .P_WEIGHT_W      (2)
    ) dut2 (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .request                  (req2),
        .weight                   (wt2),
        .grant                    (gnt2),
        .grant_accept             (acc2),
        .request_weight_completed (cmp2),
        .round_done               (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Monitor: outputs are valid one step after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.d2)
                    chk(e.nm, {1'b0, 1'b0, cmp2, rd2},
                        {1'b0, e.ec[1:0], e.erd});
                else
                    chk(e.nm, {cmp, rd}, {e.ec, e.erd});
            end
        end
    end

    task automatic step(input bit d2, input logic [2:0] r,
                        input logic [11:0] w, input logic [2:0] g,
                        input logic a, input logic [2:0] ec,
                        input logic erd, input string nm);
        exp_t e;
        @(negedge clk);
        if (d2) begin
            req = 3'b000; gnt = 3'b000; acc = 1'b0;
            req2 = r[1:0]; wt2 = w[3:0]; gnt2 = g[1:0]; acc2 = a;
        end else begin
            req2 = 2'b00; gnt2 = 2'b00; acc2 = 1'b0;
            req = r; wt = w; gnt = g; acc = a;
        end
        e.d2 = d2; e.ec = ec; e.erd = erd; e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; wt = 12'h111; gnt = '0; acc = 1'b0;
        req2 = '0; wt2 = 4'b0101; gnt2 = '0; acc2 = 1'b0;
        #3;
        chk("reset_cmp", {1'b0, cmp}, 4'b0000);
        chk("reset_rd", {3'b000, rd}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // weights {1,2,3}: order 0,1,2,1,2,2 then closing grant
        for (int n = 0; n < 2; n++) begin
            step(0, 3'b111, 12'h321, 3'b001, 1, 3'b001, n == 1, "w123_g0");
            step(0, 3'b111, 12'h321, 3'b010, 1, 3'b001, 0, "w123_g1a");
            step(0, 3'b111, 12'h321, 3'b100, 1, 3'b001, 0, "w123_g2a");
            step(0, 3'b111, 12'h321, 3'b010, 1, 3'b011, 0, "w123_g1b");
            step(0, 3'b111, 12'h321, 3'b100, 1, 3'b011, 0, "w123_g2b");
            step(0, 3'b111, 12'h321, 3'b100, 1, 3'b111, 0, "w123_g2c");
        end
        step(0, 3'b111, 12'h321, 3'b001, 1, 3'b001, 1, "w123_close");
        step(0, 3'b000, 12'h321, 3'b000, 0, 3'b000, 0, "w123_idle");

        // only requester 1, weight 2: close every second accept
        step(0, 3'b010, 12'h222, 3'b010, 1, 3'b000, 0, "solo_c1");
        step(0, 3'b010, 12'h222, 3'b010, 1, 3'b010, 0, "solo_c2");
        step(0, 3'b010, 12'h222, 3'b010, 1, 3'b000, 1, "solo_close1");
        step(0, 3'b010, 12'h222, 3'b010, 1, 3'b010, 0, "solo_c2b");
        step(0, 3'b010, 12'h222, 3'b010, 1, 3'b000, 1, "solo_close2");
        step(0, 3'b000, 12'h222, 3'b000, 0, 3'b000, 0, "solo_idle");

        // weight 0 acts as weight 1
        step(0, 3'b111, 12'h110, 3'b001, 1, 3'b001, 0, "w0_g0");
        step(0, 3'b111, 12'h110, 3'b010, 1, 3'b011, 0, "w0_g1");
        step(0, 3'b111, 12'h110, 3'b100, 1, 3'b111, 0, "w0_g2");
        step(0, 3'b111, 12'h110, 3'b001, 1, 3'b001, 1, "w0_close");
        step(0, 3'b000, 12'h110, 3'b000, 0, 3'b000, 0, "w0_idle");

        // no-op accepts, then mid-round idle clear
        step(0, 3'b111, 12'h321, 3'b001, 1, 3'b001, 0, "mid_g0");
        step(0, 3'b111, 12'h321, 3'b000, 1, 3'b001, 0, "acc_no_gnt");
        step(0, 3'b111, 12'h321, 3'b010, 0, 3'b001, 0, "gnt_no_acc");
        step(0, 3'b000, 12'h321, 3'b000, 0, 3'b000, 0, "mid_idle");
        step(0, 3'b111, 12'h321, 3'b010, 1, 3'b000, 0, "mid_fresh");
        step(0, 3'b000, 12'h321, 3'b000, 0, 3'b000, 0, "mid_idle2");

        // 2-bit counters: live weight raise and saturation
        step(1, 3'b011, 12'h00E, 3'b001, 1, 3'b000, 0, "sat_c1");
        step(1, 3'b011, 12'h00E, 3'b001, 1, 3'b001, 0, "sat_c2");
        step(1, 3'b011, 12'h00F, 3'b000, 0, 3'b000, 0, "sat_raise");
        step(1, 3'b011, 12'h00F, 3'b001, 1, 3'b001, 0, "sat_c3");
        step(1, 3'b011, 12'h00F, 3'b001, 1, 3'b001, 0, "sat_hold1");
        step(1, 3'b011, 12'h00F, 3'b001, 1, 3'b001, 0, "sat_hold2");

        // async reset while round_done is high
        step(0, 3'b111, 12'h111, 3'b001, 1, 3'b001, 0, "rst_g0");
        step(0, 3'b111, 12'h111, 3'b010, 1, 3'b011, 0, "rst_g1");
        step(0, 3'b111, 12'h111, 3'b100, 1, 3'b111, 0, "rst_g2");
        step(0, 3'b111, 12'h111, 3'b001, 1, 3'b001, 1, "rst_close");
        @(negedge clk);
        acc = 1'b0; gnt = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cmp", {1'b0, cmp}, 4'b0000);
        chk("async_rst_rd", {3'b000, rd}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 3'b111, 12'h111, 3'b010, 1, 3'b010, 0, "post_rst_g1");
        step(0, 3'b000, 12'h111, 3'b000, 0, 3'b000, 0, "post_rst_idle");

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
